// File: rtl/ship_motion_pkg.sv
// Shared definitions for the ship motion block: FSM encodings, heading table
// and the default screen/sprite geometry.
package ship_motion_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UPDATE = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_DRAW   = 2'd3;

  localparam int SPRITE_SIZE  = 32;
  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;
  localparam logic [4:0] HEADING_MAX = 5'd23;

  // Direction code {xs, xm[1:0], ys, ym[1:0]}; idx 0 points straight up, steps go clockwise.
  function automatic logic [5:0] heading_lut(input logic [4:0] idx);
    logic [5:0] d;
    case (idx)
      5'd0:  d = 6'b000111;
      5'd1:  d = 6'b001111;
      5'd2:  d = 6'b001110;
      5'd3:  d = 6'b001101;
      5'd4:  d = 6'b010101;
      5'd5:  d = 6'b011101;
      5'd6:  d = 6'b011100;
      5'd7:  d = 6'b011001;
      5'd8:  d = 6'b010001;
      5'd9:  d = 6'b001001;
      5'd10: d = 6'b001010;
      5'd11: d = 6'b001011;
      5'd12: d = 6'b000011;
      5'd13: d = 6'b101011;
      5'd14: d = 6'b101010;
      5'd15: d = 6'b101001;
      5'd16: d = 6'b110001;
      5'd17: d = 6'b111001;
      5'd18: d = 6'b111000;
      5'd19: d = 6'b111101;
      5'd20: d = 6'b110101;
      5'd21: d = 6'b101101;
      5'd22: d = 6'b101110;
      5'd23: d = 6'b101111;
      default: d = 6'b000111;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ship_motion_screen_wrap.sv
// Adds a small signed step to a screen coordinate and wraps it into 0..MOD-1.
module ship_motion_screen_wrap #(
  parameter int MOD = 320
) (
  input  logic              [9:0] pos,
  input  logic signed       [2:0] delta,
  output logic              [9:0] wrapped
);

  localparam logic signed [10:0] MOD_S = 11'(MOD);

  logic signed [10:0] sum;

  // A step never exceeds one modulus, so a single add or subtract is exact.
  always_comb begin
    sum = $signed({1'b0, pos}) + 11'(delta);
    if (sum < 0)
      wrapped = 10'(sum + MOD_S);
    else if (sum >= MOD_S)
      wrapped = 10'(sum - MOD_S);
    else
      wrapped = sum[9:0];
  end

endmodule

// File: rtl/ship_motion.sv
// Per-frame ship heading/position update with a plot strobe and a busy window
// covering the sprite draw.
module ship_motion
  import ship_motion_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int X_INIT      = 144,
  parameter int Y_INIT      = 104,
  parameter int ROT_DIV     = 4,
  parameter int DRAW_CYCLES = SPRITE_SIZE * SPRITE_SIZE + 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       rot_left,
  input  logic       rot_right,
  input  logic       thrust,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [5:0] direction,
  output logic       plot,
  output logic       busy,
  output logic       overrun
);

  localparam int CNT_W = $clog2(DRAW_CYCLES + 1);
  localparam int RC_W  = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;

  logic [1:0]        state;
  logic              tick_p0;
  logic [4:0]        idx, idx_nxt;
  logic [RC_W-1:0]   rot_cnt, rot_cnt_nxt;
  logic [CNT_W-1:0]  draw_cnt;
  logic [5:0]        dir_nxt;
  logic signed [2:0] dx, dy;
  logic [9:0]        x_wrap, y_wrap;

  // Heading step and the translation it implies; only committed in UPDATE.
  always_comb begin
    idx_nxt     = idx;
    rot_cnt_nxt = '0;
    if (rot_left ^ rot_right) begin
      if (rot_cnt == RC_W'(ROT_DIV - 1)) begin
        if (rot_left)
          idx_nxt = (idx == 5'd0) ? HEADING_MAX : idx - 5'd1;
        else
          idx_nxt = (idx == HEADING_MAX) ? 5'd0 : idx + 5'd1;
      end else begin
        rot_cnt_nxt = rot_cnt + 1'b1;
      end
    end
    dir_nxt = heading_lut(idx_nxt);
    dx = '0;
    dy = '0;
    if (thrust) begin
      dx = dir_nxt[5] ? -$signed({1'b0, dir_nxt[4:3]}) : $signed({1'b0, dir_nxt[4:3]});
      dy = dir_nxt[2] ? -$signed({1'b0, dir_nxt[1:0]}) : $signed({1'b0, dir_nxt[1:0]});
    end
  end

  ship_motion_screen_wrap #(.MOD(SCREEN_W)) u_wrap_x (
    .pos     (x_pos),
    .delta   (dx),
    .wrapped (x_wrap)
  );

  ship_motion_screen_wrap #(.MOD(SCREEN_H)) u_wrap_y (
    .pos     (y_pos),
    .delta   (dy),
    .wrapped (y_wrap)
  );

  // frame_tick is registered once, so UPDATE starts two cycles after the pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      tick_p0   <= 1'b0;
      idx       <= 5'd0;
      rot_cnt   <= '0;
      draw_cnt  <= '0;
      direction <= 6'b000111;
      x_pos     <= 10'(X_INIT);
      y_pos     <= 10'(Y_INIT);
      overrun   <= 1'b0;
    end else begin
      tick_p0 <= frame_tick;
      overrun <= tick_p0 && (state != S_IDLE);
      case (state)
        S_IDLE: if (tick_p0) state <= S_UPDATE;
        S_UPDATE: begin
          idx       <= idx_nxt;
          rot_cnt   <= rot_cnt_nxt;
          direction <= dir_nxt;
          x_pos     <= x_wrap;
          y_pos     <= y_wrap;
          state     <= S_ISSUE;
        end
        S_ISSUE: begin
          draw_cnt <= CNT_W'(DRAW_CYCLES - 1);
          state    <= S_DRAW;
        end
        default: begin
          if (draw_cnt == '0) state <= S_IDLE;
          else draw_cnt <= draw_cnt - 1'b1;
        end
      endcase
    end
  end

  assign plot = (state == S_ISSUE);
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ship_motion.sv
// Self-checking bench for ship_motion: spec-default instance driven from a
// vector table through a scoreboard, plus a fast instance for wrap/heading sweeps.
module tb_ship_motion;

  typedef struct {
    logic       rl;
    logic       rr;
    logic       th;
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] dir;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       frame_tick, rot_left, rot_right, thrust;
  logic [9:0] x_pos, y_pos;
  logic [5:0] direction;
  logic       plot, busy, overrun;

  logic       f_tick, f_rl, f_rr, f_th;
  logic [9:0] fx, fy;
  logic [5:0] fdir;
  logic       f_plot, f_busy, f_ovr;

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt = 0;
  int plot_cnt = 0;
  int ovr_cnt = 0;

  vec_t main_tbl[16];
  vec_t fast_tbl[29];
  vec_t exp_q[$];
  vec_t sb_e;

  ship_motion u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .rot_left   (rot_left),
    .rot_right  (rot_right),
    .thrust     (thrust),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .direction  (direction),
    .plot       (plot),
    .busy       (busy),
    .overrun    (overrun)
  );

  ship_motion #(.X_INIT(318), .Y_INIT(238), .ROT_DIV(1), .DRAW_CYCLES(4)) u_fast (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (f_tick),
    .rot_left   (f_rl),
    .rot_right  (f_rr),
    .thrust     (f_th),
    .x_pos      (fx),
    .y_pos      (fy),
    .direction  (fdir),
    .plot       (f_plot),
    .busy       (f_busy),
    .overrun    (f_ovr)
  );

  function automatic vec_t mk(input logic rl, input logic rr, input logic th,
                              input int x, input int y, input logic [5:0] d);
    vec_t v;
    v.rl = rl; v.rr = rr; v.th = th;
    v.x = 10'(x); v.y = 10'(y); v.dir = d;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (plot) plot_cnt++;
    if (overrun) ovr_cnt++;
  end

  // Scoreboard: each plot strobe retires the oldest expected frame result.
  always @(negedge clk) begin
    if (plot) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL plot_unexpected: got plot=1, required no pending frame");
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_x_pos", int'(x_pos), int'(sb_e.x));
        chk("sb_y_pos", int'(y_pos), int'(sb_e.y));
        chk("sb_direction", int'(direction), int'(sb_e.dir));
      end
    end
  end

  task automatic main_frame(input vec_t v, input bit inject);
    int lat;
    int guard;
    exp_q.push_back(v);
    @(negedge clk);
    rot_left = v.rl; rot_right = v.rr; thrust = v.th;
    busy_cnt = 0; plot_cnt = 0; ovr_cnt = 0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    lat = 1;
    while (!plot && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("plot_latency", lat, 3);
    if (inject) begin
      repeat (50) @(negedge clk);
      frame_tick = 1'b1; rot_left = 1'b1; rot_right = 1'b0; thrust = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0; rot_left = v.rl; rot_right = v.rr; thrust = v.th;
    end
    guard = 0;
    while (busy && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("busy_timeout", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("busy_cycles", busy_cnt, 1032);
    chk("plot_count", plot_cnt, 1);
    chk("overrun_count", ovr_cnt, inject ? 1 : 0);
    chk("sb_drain", exp_q.size(), 0);
    rot_left = 1'b0; rot_right = 1'b0; thrust = 1'b0;
  endtask

  task automatic fast_frame(input vec_t v, input int n);
    int guard;
    @(negedge clk);
    f_rl = v.rl; f_rr = v.rr; f_th = v.th;
    f_tick = 1'b1;
    @(negedge clk);
    f_tick = 1'b0;
    guard = 0;
    while (!f_plot && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("fast%0d_plot", n), int'(f_plot), 1);
    chk($sformatf("fast%0d_x", n), int'(fx), int'(v.x));
    chk($sformatf("fast%0d_y", n), int'(fy), int'(v.y));
    chk($sformatf("fast%0d_dir", n), int'(fdir), int'(v.dir));
    guard = 0;
    while (f_busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("fast%0d_idle", n), int'(f_busy), 0);
    f_rl = 1'b0; f_rr = 1'b0; f_th = 1'b0;
  endtask

  initial begin
    int guard;
    // Spec-default instance, ROT_DIV=4: rotation steps on every 4th held update.
    main_tbl[0]  = mk(1'b0, 1'b0, 1'b0, 144, 104, 6'b000111);
    main_tbl[1]  = mk(1'b0, 1'b0, 1'b1, 144, 101, 6'b000111);
    main_tbl[2]  = mk(1'b0, 1'b1, 1'b0, 144, 101, 6'b000111);
    main_tbl[3]  = mk(1'b0, 1'b1, 1'b0, 144, 101, 6'b000111);
    main_tbl[4]  = mk(1'b0, 1'b1, 1'b0, 144, 101, 6'b000111);
    main_tbl[5]  = mk(1'b0, 1'b1, 1'b0, 144, 101, 6'b001111);
    main_tbl[6]  = mk(1'b1, 1'b1, 1'b0, 144, 101, 6'b001111);
    main_tbl[7]  = mk(1'b1, 1'b0, 1'b0, 144, 101, 6'b001111);
    main_tbl[8]  = mk(1'b1, 1'b0, 1'b0, 144, 101, 6'b001111);
    main_tbl[9]  = mk(1'b1, 1'b0, 1'b0, 144, 101, 6'b001111);
    main_tbl[10] = mk(1'b1, 1'b0, 1'b0, 144, 101, 6'b000111);
    main_tbl[11] = mk(1'b1, 1'b0, 1'b0, 144, 101, 6'b000111);
    main_tbl[12] = mk(1'b1, 1'b0, 1'b0, 144, 101, 6'b000111);
    main_tbl[13] = mk(1'b1, 1'b0, 1'b0, 144, 101, 6'b000111);
    main_tbl[14] = mk(1'b1, 1'b0, 1'b1, 143,  98, 6'b101111);
    main_tbl[15] = mk(1'b1, 1'b1, 1'b1, 142,  95, 6'b101111);

    // Fast instance, ROT_DIV=1, starts at (318,238): full heading sweep and wraps.
    fast_tbl[0]  = mk(1'b0, 1'b1, 1'b0, 318, 238, 6'b001111);
    fast_tbl[1]  = mk(1'b0, 1'b1, 1'b0, 318, 238, 6'b001110);
    fast_tbl[2]  = mk(1'b0, 1'b1, 1'b0, 318, 238, 6'b001101);
    fast_tbl[3]  = mk(1'b0, 1'b1, 1'b0, 318, 238, 6'b010101);
    fast_tbl[4]  = mk(1'b0, 1'b1, 1'b0, 318, 238, 6'b011101);
    fast_tbl[5]  = mk(1'b0, 1'b1, 1'b0, 318, 238, 6'b011100);
    fast_tbl[6]  = mk(1'b0, 1'b0, 1'b1,   1, 238, 6'b011100);
    fast_tbl[7]  = mk(1'b0, 1'b1, 1'b0,   1, 238, 6'b011001);
    fast_tbl[8]  = mk(1'b0, 1'b1, 1'b0,   1, 238, 6'b010001);
    fast_tbl[9]  = mk(1'b0, 1'b1, 1'b0,   1, 238, 6'b001001);
    fast_tbl[10] = mk(1'b0, 1'b1, 1'b0,   1, 238, 6'b001010);
    fast_tbl[11] = mk(1'b0, 1'b1, 1'b0,   1, 238, 6'b001011);
    fast_tbl[12] = mk(1'b0, 1'b1, 1'b0,   1, 238, 6'b000011);
    fast_tbl[13] = mk(1'b0, 1'b0, 1'b1,   1,   1, 6'b000011);
    fast_tbl[14] = mk(1'b0, 1'b1, 1'b0,   1,   1, 6'b101011);
    fast_tbl[15] = mk(1'b0, 1'b1, 1'b0,   1,   1, 6'b101010);
    fast_tbl[16] = mk(1'b0, 1'b1, 1'b0,   1,   1, 6'b101001);
    fast_tbl[17] = mk(1'b0, 1'b1, 1'b0,   1,   1, 6'b110001);
    fast_tbl[18] = mk(1'b0, 1'b1, 1'b0,   1,   1, 6'b111001);
    fast_tbl[19] = mk(1'b0, 1'b1, 1'b0,   1,   1, 6'b111000);
    fast_tbl[20] = mk(1'b0, 1'b0, 1'b1, 318,   1, 6'b111000);
    fast_tbl[21] = mk(1'b0, 1'b1, 1'b0, 318,   1, 6'b111101);
    fast_tbl[22] = mk(1'b0, 1'b1, 1'b0, 318,   1, 6'b110101);
    fast_tbl[23] = mk(1'b0, 1'b1, 1'b0, 318,   1, 6'b101101);
    fast_tbl[24] = mk(1'b0, 1'b1, 1'b0, 318,   1, 6'b101110);
    fast_tbl[25] = mk(1'b0, 1'b1, 1'b0, 318,   1, 6'b101111);
    fast_tbl[26] = mk(1'b0, 1'b1, 1'b1, 318, 238, 6'b000111);
    fast_tbl[27] = mk(1'b1, 1'b0, 1'b0, 318, 238, 6'b101111);
    fast_tbl[28] = mk(1'b1, 1'b1, 1'b1, 317, 235, 6'b101111);

    reset_n = 1'b0;
    frame_tick = 1'b0; rot_left = 1'b0; rot_right = 1'b0; thrust = 1'b0;
    f_tick = 1'b0; f_rl = 1'b0; f_rr = 1'b0; f_th = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x_pos", int'(x_pos), 144);
    chk("rst_y_pos", int'(y_pos), 104);
    chk("rst_direction", int'(direction), 7);
    chk("rst_busy", int'(busy), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_fast_x", int'(fx), 318);
    chk("rst_fast_y", int'(fy), 238);
    reset_n = 1'b1;

    for (int i = 0; i < 29; i++) fast_frame(fast_tbl[i], i);
    chk("fast_overrun", int'(f_ovr), 0);

    for (int i = 0; i < 16; i++) main_frame(main_tbl[i], i == 6);

    // Reset in the middle of a draw: everything returns to the reset state at once.
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 142, 95, 6'b101111));
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    guard = 0;
    while (!plot && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("mid_plot_seen", int'(plot), 1);
    repeat (100) @(negedge clk);
    chk("mid_busy_before", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_x_pos", int'(x_pos), 144);
    chk("mid_rst_y_pos", int'(y_pos), 104);
    chk("mid_rst_direction", int'(direction), 7);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_plot", int'(plot), 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_sb_drain", exp_q.size(), 0);

    // Heading and rotation counter restart from zero after the reset.
    main_frame(mk(1'b0, 1'b0, 1'b1, 144, 101, 6'b000111), 1'b0);
    main_frame(mk(1'b0, 1'b1, 1'b0, 144, 101, 6'b000111), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
